// File: rtl/lif_tdm_scheduler_if.sv
// Spike-event stream between the scheduler's event FIFO and its consumer.
interface lif_tdm_scheduler_if #(
    parameter int unsigned NUM_NEURONS = 4
) ();
    localparam int unsigned ID_W = $clog2(NUM_NEURONS);

    logic            evt_valid_o;
    logic [ID_W-1:0] evt_id_o;
    logic            evt_ready_i;

    modport master (output evt_valid_o, output evt_id_o, input evt_ready_i);
    modport slave  (input evt_valid_o, input evt_id_o, output evt_ready_i);
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update
// datapath walks all virtual neurons once per timestep tick, reports a spike
// vector per timestep and streams fired neuron IDs through a small FIFO.
module lif_tdm_scheduler #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned LEAK_SHIFT  = 3,
    parameter logic [7:0]  THRESHOLD   = 8'd200,
    parameter int unsigned REFRACTORY  = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                              clk_i,
    input  logic                              reset,
    input  logic                              tick_i,
    input  logic [8*NUM_NEURONS-1:0]          current_i,
    input  logic [$clog2(NUM_NEURONS)-1:0]    sel_i,
    output logic [7:0]                        nu_o,
    output logic [NUM_NEURONS-1:0]            spike_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              ovf_o,
    output logic                              tick_miss_o,
    lif_tdm_scheduler_if.master               evt
);
    localparam int unsigned ID_W = $clog2(NUM_NEURONS);
    localparam int unsigned RW   = (REFRACTORY < 1) ? 1 : $clog2(REFRACTORY + 1);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PW   = AW + 1;
    localparam logic [RW-1:0]   REFR_LOAD = RW'(REFRACTORY);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        idx_q, idx_d;
    logic [NUM_NEURONS-1:0] work_q, work_d;
    logic [NUM_NEURONS-1:0] spike_q;
    logic                   load, upd;

    logic [7:0]             cur_q  [NUM_NEURONS];
    logic [7:0]             v_q    [NUM_NEURONS];
    logic [RW-1:0]          refr_q [NUM_NEURONS];

    logic [7:0]             v_cur, c_cur, s_sat, v_new;
    logic [RW-1:0]          r_cur, r_new;
    logic [8:0]             sum9;
    logic                   in_refr, fire;

    logic [ID_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_q, rd_q;
    logic                   empty, full, push, pop, push_ok, drop;
    logic                   ovf_q, miss_q;

    // LIF update of the currently selected neuron (leak, integrate, saturate, fire)
    always_comb begin
        v_cur   = v_q[idx_q];
        c_cur   = cur_q[idx_q];
        r_cur   = refr_q[idx_q];
        sum9    = {1'b0, v_cur} - {1'b0, (v_cur >> LEAK_SHIFT)} + {1'b0, c_cur};
        s_sat   = sum9[8] ? 8'hFF : sum9[7:0];
        in_refr = (r_cur != '0);
        fire    = !in_refr && (s_sat >= THRESHOLD);
        v_new   = (in_refr || fire) ? '0 : s_sat;
        r_new   = in_refr ? (r_cur - RW'(1)) : (fire ? REFR_LOAD : '0);
    end

    // Sequencer next-state: IDLE -> UPDATE (one neuron per cycle) -> DONE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        work_d  = work_q;
        load    = 1'b0;
        upd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_i) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                upd = 1'b1;
                if (fire) work_d[idx_q] = 1'b1;
                if (idx_q == LAST_IDX) state_d = DONE;
                else                   idx_d   = idx_q + ID_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state; spike_o is loaded with the finished vector on entry to DONE
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            work_q  <= '0;
            spike_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            if (upd && (state_d == DONE)) spike_q <= work_d;
        end
    end

    // Per-neuron current snapshot, membrane potential and refractory counters
    always_ff @(posedge clk_i) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                cur_q[i]  <= '0;
                v_q[i]    <= '0;
                refr_q[i] <= '0;
            end
        end else begin
            if (load) begin
                for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                    cur_q[i] <= current_i[8*i +: 8];
                end
            end
            if (upd) begin
                v_q[idx_q]    <= v_new;
                refr_q[idx_q] <= r_new;
            end
        end
    end

    // Event FIFO control: a pop frees a slot for a simultaneous push even when full
    always_comb begin
        push    = upd && fire;
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop     = !empty && evt.evt_ready_i;
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
    end

    // Event FIFO pointers and sticky error flags
    always_ff @(posedge clk_i) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + PW'(1);
            if (pop)     rd_q <= rd_q + PW'(1);
            if (drop)    ovf_q <= 1'b1;
            if (tick_i && (state_q != IDLE)) miss_q <= 1'b1;
        end
    end

    // Event FIFO storage
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= idx_q;
    end

    assign evt.evt_valid_o = !empty;
    assign evt.evt_id_o    = mem_q[rd_q[AW-1:0]];
    assign nu_o            = v_q[sel_i];
    assign spike_o         = spike_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign ovf_o           = ovf_q;
    assign tick_miss_o     = miss_q;
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Scoreboard bench for lif_tdm_scheduler: a timestep-level LIF model predicts
// spike vectors, potentials and event IDs; a negedge monitor checks outputs.
`timescale 1ns/1ps
module tb_lif_tdm_scheduler;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int LS    = 3;
    localparam int TH    = 200;
    localparam int REF   = 2;
    localparam int IDW   = 2;

    logic           clk_i = 1'b0;
    logic           reset;
    logic           tick_i;
    logic [8*N-1:0] current_i;
    logic [IDW-1:0] sel_i;
    logic [7:0]     nu_o;
    logic [N-1:0]   spike_o;
    logic           busy_o, done_o, ovf_o, tick_miss_o;

    lif_tdm_scheduler_if #(.NUM_NEURONS(N)) evt_if ();

    lif_tdm_scheduler #(
        .NUM_NEURONS(N),
        .LEAK_SHIFT (LS),
        .THRESHOLD  (8'd200),
        .REFRACTORY (REF),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .tick_i     (tick_i),
        .current_i  (current_i),
        .sel_i      (sel_i),
        .nu_o       (nu_o),
        .spike_o    (spike_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .ovf_o      (ovf_o),
        .tick_miss_o(tick_miss_o),
        .evt        (evt_if)
    );

    always #10 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    // Reference state: potentials, refractory counts, currents, sticky flags
    int mv [N];
    int mr [N];
    int mc [N];
    int m_ovf;
    int exp_v0 [6] = '{100, 188, 0, 0, 0, 100};

    logic [N-1:0] exp_spk_q [$];
    int           exp_evt_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk_i) begin
        if (!reset) begin
            if (done_o) begin
                done_cnt++;
                if (exp_spk_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done spike=%0d", spike_o);
                end else begin
                    chk("spike_vec", int'(spike_o), int'(exp_spk_q.pop_front()));
                end
            end
            if (evt_if.evt_valid_o && evt_if.evt_ready_i) begin
                if (exp_evt_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_evt id=%0d", evt_if.evt_id_o);
                end else begin
                    chk("evt_id", int'(evt_if.evt_id_o), exp_evt_q.pop_front());
                end
            end
        end
    end

    // One timestep of the LIF rules applied to every neuron in order
    task automatic model_tick(input logic rdy);
        logic [N-1:0] sv = '0;
        int s;
        for (int k = 0; k < N; k++) begin
            if (mr[k] > 0) begin
                mv[k] = 0;
                mr[k] = mr[k] - 1;
            end else begin
                s = mv[k] - (mv[k] >> LS) + mc[k];
                if (s > 255) s = 255;
                if (s >= TH) begin
                    sv[k] = 1'b1;
                    mv[k] = 0;
                    mr[k] = REF;
                    if (rdy || exp_evt_q.size() < DEPTH) exp_evt_q.push_back(k);
                    else m_ovf = 1;
                end else begin
                    mv[k] = s;
                end
            end
        end
        exp_spk_q.push_back(sv);
    endtask

    task automatic set_currents();
        for (int k = 0; k < N; k++) current_i[8*k +: 8] = 8'(mc[k]);
    endtask

    task automatic check_nu(input string tag);
        for (int k = 0; k < N; k++) begin
            sel_i = IDW'(k);
            #1;
            chk($sformatf("%s_nu%0d", tag, k), int'(nu_o), mv[k]);
        end
    endtask

    // Issue one tick (optionally a stray second tick at cycle miss_at), wait for done
    task automatic run_tick(input int miss_at);
        int k = 0;
        bit got = 0;
        model_tick(evt_if.evt_ready_i);
        tick_i = 1'b1;
        while (k < 40 && !got) begin
            @(posedge clk_i); #1;
            k++;
            if (k == 1) tick_i = 1'b0;
            if (miss_at != 0) begin
                if (k == miss_at) tick_i = 1'b1;
                else if (k == miss_at + 1) tick_i = 1'b0;
            end
            if (done_o) got = 1;
        end
        tick_i = 1'b0;
        chk("done_latency", k, N + 1);
        @(posedge clk_i); #1;
        chk("busy_after_done", int'(busy_o), 0);
        check_nu("tick");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin mv[k] = 0; mr[k] = 0; end
        m_ovf = 0;
        exp_spk_q.delete();
        exp_evt_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w;
        reset = 1'b1; tick_i = 1'b0; current_i = '0; sel_i = '0;
        evt_if.evt_ready_i = 1'b0;
        for (int k = 0; k < N; k++) mc[k] = 0;
        @(posedge clk_i); #1;

        // Reset state
        do_reset();
        check_nu("reset");
        chk("reset_spike", int'(spike_o), 0);
        chk("reset_valid", int'(evt_if.evt_valid_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_done", int'(done_o), 0);
        chk("reset_ovf", int'(ovf_o), 0);
        chk("reset_miss", int'(tick_miss_o), 0);

        // Single neuron integrating to threshold, then refractory
        evt_if.evt_ready_i = 1'b1;
        mc[0] = 100;
        set_currents();
        for (int i = 0; i < 6; i++) begin
            run_tick(0);
            sel_i = '0; #1;
            chk("v0_sequence", int'(nu_o), exp_v0[i]);
            if (i == 2) chk("spike_tick3", int'(spike_o), 1);
        end
        repeat (3) @(posedge clk_i); #1;
        chk("evt_drained_1", exp_evt_q.size(), 0);

        // FIFO fill and overflow with consumer stalled
        do_reset();
        evt_if.evt_ready_i = 1'b0;
        for (int k = 0; k < N; k++) mc[k] = 255;
        set_currents();
        for (int i = 0; i < 6; i++) run_tick(0);
        chk("ovf_model", int'(ovf_o), m_ovf);
        chk("ovf_set", int'(ovf_o), 1);
        chk("fifo_valid_full", int'(evt_if.evt_valid_o), 1);
        evt_if.evt_ready_i = 1'b1;
        w = 0;
        while (evt_if.evt_valid_o && w < 20) begin @(posedge clk_i); #1; w++; end
        chk("drain_valid_low", int'(evt_if.evt_valid_o), 0);
        chk("drain_count", w, DEPTH);
        chk("evt_drained_2", exp_evt_q.size(), 0);

        // Tick while busy is ignored and flagged
        do_reset();
        for (int k = 0; k < N; k++) mc[k] = 5;
        set_currents();
        d0 = done_cnt;
        run_tick(2);
        repeat (4) @(posedge clk_i); #1;
        chk("tick_miss", int'(tick_miss_o), 1);
        chk("single_done", done_cnt - d0, 1);
        chk("busy_idle_after_miss", int'(busy_o), 0);

        // Reset in the second UPDATE cycle discards the timestep
        do_reset();
        for (int k = 0; k < N; k++) mc[k] = 10;
        set_currents();
        tick_i = 1'b1;
        @(posedge clk_i); #1;
        tick_i = 1'b0;
        @(posedge clk_i); #1;
        sel_i = '0; #1;
        chk("v0_before_reset", int'(nu_o), 10);
        reset = 1'b1;
        @(posedge clk_i); #1;
        reset = 1'b0;
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        chk("midrst_valid", int'(evt_if.evt_valid_o), 0);
        check_nu("midrst");
        repeat (6) @(posedge clk_i); #1;
        run_tick(0);

        // Randomized timesteps with random consumer readiness
        for (int i = 0; i < 40; i++) begin
            evt_if.evt_ready_i = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) mc[k] = int'($urandom_range(0, 255));
            set_currents();
            run_tick(0);
            chk("rand_ovf", int'(ovf_o), m_ovf);
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            #1;
        end
        evt_if.evt_ready_i = 1'b1;
        repeat (DEPTH + 4) @(posedge clk_i);
        #1;
        chk("final_evt_left", exp_evt_q.size(), 0);
        chk("final_spk_left", exp_spk_q.size(), 0);
        chk("final_valid", int'(evt_if.evt_valid_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
